// File: rtl/vga_rect_plotter.sv
// Raster-order rectangle draw engine for the vga_adapter plot interface (fill, outline, clear).
// Optional macro VGA_RECT_READY_EN adds a pixel_ready back-pressure input.
module vga_rect_plotter #(
  parameter int SCREEN_W    = 160,
  parameter int SCREEN_H    = 120,
  parameter int X_WIDTH     = 8,
  parameter int Y_WIDTH     = 7,
  parameter int COLOUR_BITS = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [X_WIDTH-1:0]     req_x,
  input  logic [Y_WIDTH-1:0]     req_y,
  input  logic [X_WIDTH-1:0]     req_w,
  input  logic [Y_WIDTH-1:0]     req_h,
  input  logic [COLOUR_BITS-1:0] req_colour,
`ifdef VGA_RECT_READY_EN
  input  logic                   pixel_ready,
`endif
  output logic [X_WIDTH-1:0]     x,
  output logic [Y_WIDTH-1:0]     y,
  output logic [COLOUR_BITS-1:0] colour,
  output logic                   plot,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                   state_r, state_n;
  logic [X_WIDTH-1:0]       x0_r, x0_n, w_r, w_n, cx_r, cx_n;
  logic [Y_WIDTH-1:0]       y0_r, y0_n, h_r, h_n, cy_r, cy_n;
  logic                     outline_r, outline_n;
  logic [COLOUR_BITS-1:0]   col_r, col_n;
  logic [X_WIDTH-1:0]       x_r, x_n;
  logic [Y_WIDTH-1:0]       y_r, y_n;
  logic [COLOUR_BITS-1:0]   colour_r, colour_n;
  logic                     plot_r, plot_n, busy_r, busy_n, done_r, done_n;

  logic                     acc_clear_s, acc_empty_s, acc_plot_s;
  logic [X_WIDTH-1:0]       acc_x0_s, acc_w_s;
  logic [Y_WIDTH-1:0]       acc_y0_s, acc_h_s;
  logic                     x_wrap_s, last_s, adv_plot_s, adv_en_s;
  logic [X_WIDTH-1:0]       adv_cx_s;
  logic [Y_WIDTH-1:0]       adv_cy_s;
  logic [X_WIDTH:0]         adv_xs_s;
  logic [Y_WIDTH:0]         adv_ys_s;

  // Sums are one bit wider than the coordinates so off-screen pixels never wrap back on screen.
  function automatic logic in_screen(input logic [X_WIDTH:0] xs, input logic [Y_WIDTH:0] ys);
    return (xs < (X_WIDTH+1)'(SCREEN_W)) && (ys < (Y_WIDTH+1)'(SCREEN_H));
  endfunction

  function automatic logic on_border(input logic [X_WIDTH-1:0] cx, input logic [Y_WIDTH-1:0] cy,
                                     input logic [X_WIDTH-1:0] w,  input logic [Y_WIDTH-1:0] h);
    return (cx == X_WIDTH'(0)) || (cx == w - X_WIDTH'(1)) ||
           (cy == Y_WIDTH'(0)) || (cy == h - Y_WIDTH'(1));
  endfunction

`ifdef VGA_RECT_READY_EN
  assign adv_en_s = pixel_ready;
`else
  assign adv_en_s = 1'b1;
`endif

  // Datapath: first pixel of an incoming command and the next pixel of the active one.
  always_comb begin
    acc_clear_s = (mode == 2'd2);
    if (acc_clear_s) begin
      acc_x0_s = X_WIDTH'(0);
      acc_y0_s = Y_WIDTH'(0);
      acc_w_s  = X_WIDTH'(SCREEN_W);
      acc_h_s  = Y_WIDTH'(SCREEN_H);
    end else begin
      acc_x0_s = req_x;
      acc_y0_s = req_y;
      acc_w_s  = req_w;
      acc_h_s  = req_h;
    end
    acc_empty_s = (acc_w_s == X_WIDTH'(0)) || (acc_h_s == Y_WIDTH'(0));
    acc_plot_s  = in_screen({1'b0, acc_x0_s}, {1'b0, acc_y0_s});

    x_wrap_s = (cx_r == w_r - X_WIDTH'(1));
    last_s   = x_wrap_s && (cy_r == h_r - Y_WIDTH'(1));
    if (x_wrap_s) begin
      adv_cx_s = X_WIDTH'(0);
      adv_cy_s = cy_r + Y_WIDTH'(1);
    end else begin
      adv_cx_s = cx_r + X_WIDTH'(1);
      adv_cy_s = cy_r;
    end
    adv_xs_s   = {1'b0, x0_r} + {1'b0, adv_cx_s};
    adv_ys_s   = {1'b0, y0_r} + {1'b0, adv_cy_s};
    adv_plot_s = in_screen(adv_xs_s, adv_ys_s) &&
                 (!outline_r || on_border(adv_cx_s, adv_cy_s, w_r, h_r));
  end

  // Next-state and next-output logic; every register holds unless a case below updates it.
  always_comb begin
    state_n   = state_r;
    x0_n      = x0_r;
    y0_n      = y0_r;
    w_n       = w_r;
    h_n       = h_r;
    cx_n      = cx_r;
    cy_n      = cy_r;
    outline_n = outline_r;
    col_n     = col_r;
    x_n       = x_r;
    y_n       = y_r;
    colour_n  = colour_r;
    plot_n    = plot_r;
    busy_n    = busy_r;
    done_n    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        plot_n = 1'b0;
        busy_n = 1'b0;
        if (start) begin
          x0_n      = acc_x0_s;
          y0_n      = acc_y0_s;
          w_n       = acc_w_s;
          h_n       = acc_h_s;
          outline_n = (mode == 2'd1);
          col_n     = req_colour;
          cx_n      = X_WIDTH'(0);
          cy_n      = Y_WIDTH'(0);
          if (acc_empty_s) begin
            state_n = ST_DONE;
            done_n  = 1'b1;
          end else begin
            state_n  = ST_DRAW;
            busy_n   = 1'b1;
            x_n      = acc_x0_s;
            y_n      = acc_y0_s;
            colour_n = req_colour;
            plot_n   = acc_plot_s;
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_DRAW: begin
        if (!adv_en_s) begin
          state_n = ST_DRAW;
        end else if (last_s) begin
          state_n = ST_DONE;
          plot_n  = 1'b0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else begin
          cx_n   = adv_cx_s;
          cy_n   = adv_cy_s;
          x_n    = adv_xs_s[X_WIDTH-1:0];
          y_n    = adv_ys_s[Y_WIDTH-1:0];
          plot_n = adv_plot_s;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
        plot_n  = 1'b0;
        busy_n  = 1'b0;
      end
      default: begin
        state_n = ST_IDLE;
        plot_n  = 1'b0;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State, latched command and registered pixel outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      x0_r      <= X_WIDTH'(0);
      y0_r      <= Y_WIDTH'(0);
      w_r       <= X_WIDTH'(0);
      h_r       <= Y_WIDTH'(0);
      cx_r      <= X_WIDTH'(0);
      cy_r      <= Y_WIDTH'(0);
      outline_r <= 1'b0;
      col_r     <= COLOUR_BITS'(0);
      x_r       <= X_WIDTH'(0);
      y_r       <= Y_WIDTH'(0);
      colour_r  <= COLOUR_BITS'(0);
      plot_r    <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_n;
      x0_r      <= x0_n;
      y0_r      <= y0_n;
      w_r       <= w_n;
      h_r       <= h_n;
      cx_r      <= cx_n;
      cy_r      <= cy_n;
      outline_r <= outline_n;
      col_r     <= col_n;
      x_r       <= x_n;
      y_r       <= y_n;
      colour_r  <= colour_n;
      plot_r    <= plot_n;
      busy_r    <= busy_n;
      done_r    <= done_n;
    end
  end

  assign x      = x_r;
  assign y      = y_r;
  assign colour = colour_r;
  assign plot   = plot_r;
  assign busy   = busy_r;
  assign done   = done_r;

endmodule

// File: tb/tb_vga_rect_plotter.sv
// Directed bench for vga_rect_plotter: vector table of whole commands plus hand-timed sequences.
module tb_vga_rect_plotter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] req_x = 8'd0;
  logic [6:0] req_y = 7'd0;
  logic [7:0] req_w = 8'd0;
  logic [6:0] req_h = 7'd0;
  logic [2:0] req_colour = 3'd0;
  logic       pixel_ready = 1'b1;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, done;

  int errors = 0;
  int checks = 0;
  bit seen [0:159][0:119];

  always #5 clock = ~clock;

  vga_rect_plotter dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode),
    .req_x(req_x), .req_y(req_y), .req_w(req_w), .req_h(req_h), .req_colour(req_colour),
`ifdef VGA_RECT_READY_EN
    .pixel_ready(pixel_ready),
`endif
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
  );

  typedef struct {
    logic [1:0] m;
    int px, py, pw, ph, pc;
    int cyc, plots, fx, fy, lx, ly;
  } vec_t;

  vec_t tbl [10];

  function automatic vec_t mk(input logic [1:0] m, input int px, py, pw, ph, pc,
                              input int cyc, plots, fx, fy, lx, ly);
    vec_t v;
    v.m = m; v.px = px; v.py = py; v.pw = pw; v.ph = ph; v.pc = pc;
    v.cyc = cyc; v.plots = plots; v.fx = fx; v.fy = fy; v.lx = lx; v.ly = ly;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic issue(input logic [1:0] m, input int px, py, pw, ph, pc);
    mode = m; req_x = 8'(px); req_y = 7'(py); req_w = 8'(pw); req_h = 7'(ph);
    req_colour = 3'(pc); start = 1'b1;
  endtask

  // Runs one command to completion; t counts cycles after the accept cycle.
  task automatic run_cmd(input vec_t v, output int cyc, output int plots, output int done_at,
                         output int col_err, output int dups, output int oob,
                         output int fx, output int fy, output int lx, output int ly);
    int t;
    cyc = 0; plots = 0; done_at = -1; col_err = 0; dups = 0; oob = 0;
    fx = -1; fy = -1; lx = -1; ly = -1;
    for (int i = 0; i < 160; i++)
      for (int j = 0; j < 120; j++) seen[i][j] = 1'b0;
    @(negedge clock);
    issue(v.m, v.px, v.py, v.pw, v.ph, v.pc);
    t = 0;
    while (t < 20100) begin
      @(negedge clock);
      t++;
      if (busy) cyc++;
      if (plot) begin
        plots++;
        if (fx < 0) begin fx = int'(x); fy = int'(y); end
        lx = int'(x); ly = int'(y);
        if (colour != 3'(v.pc)) col_err++;
        if (x >= 8'd160 || y >= 7'd120) oob++;
        else begin
          if (seen[x][y]) dups++;
          seen[x][y] = 1'b1;
        end
      end
      if (done) begin
        done_at = t;
        start = 1'b0;
        break;
      end
      // Garbage commands while busy must be ignored.
      start = 1'($urandom_range(1, 0));
      req_x = 8'($urandom); req_y = 7'($urandom);
      req_w = 8'($urandom); req_h = 7'($urandom);
      mode = 2'($urandom); req_colour = 3'($urandom);
    end
    start = 1'b0;
  endtask

  initial begin
    int cyc, plots, done_at, col_err, dups, oob, fx, fy, lx, ly;
    int t, busy_cnt, done_cnt;
    int xl [0:15];
    int pl [0:15];
    int exp_x [0:5];
    int exp_y [0:5];

    tbl[0] = mk(2'd0, 10, 20, 3, 2, 5,      6,     6, 10, 20,  12,  21);
    tbl[1] = mk(2'd1,  0,  0, 4, 3, 2,     12,    10,  0,  0,   3,   2);
    tbl[2] = mk(2'd0, 158, 119, 4, 2, 7,    8,     2, 158, 119, 159, 119);
    tbl[3] = mk(2'd2, 50, 60, 3, 3, 0,  19200, 19200,  0,  0, 159, 119);
    tbl[4] = mk(2'd0,  4,  4, 0, 5, 1,      0,     0, -1, -1,  -1,  -1);
    tbl[5] = mk(2'd3,  5,  6, 2, 2, 3,      4,     4,  5,  6,   6,   7);
    tbl[6] = mk(2'd1,  7,  8, 1, 1, 6,      1,     1,  7,  8,   7,   8);
    tbl[7] = mk(2'd1, 100, 50, 3, 3, 4,     9,     8, 100, 50, 102,  52);
    tbl[8] = mk(2'd0,  9,  9, 4, 0, 2,      0,     0, -1, -1,  -1,  -1);
    tbl[9] = mk(2'd0,  0, 118, 2, 4, 1,     8,     4,  0, 118,  1, 119);

    exp_x = '{10, 11, 12, 10, 11, 12};
    exp_y = '{20, 20, 20, 21, 21, 21};

    // Reset state
    repeat (3) @(negedge clock);
    chk("reset_x", int'(x), 0);
    chk("reset_y", int'(y), 0);
    chk("reset_colour", int'(colour), 0);
    chk("reset_plot", int'(plot), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    reset = 1'b0;
    @(negedge clock);

    // Exact pixel sequence of a 3x2 fill
    issue(2'd0, 10, 20, 3, 2, 5);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      start = 1'b0;
      chk($sformatf("seq_plot%0d", i), int'(plot), 1);
      chk($sformatf("seq_x%0d", i), int'(x), exp_x[i]);
      chk($sformatf("seq_y%0d", i), int'(y), exp_y[i]);
      chk($sformatf("seq_col%0d", i), int'(colour), 5);
      chk($sformatf("seq_busy%0d", i), int'(busy), 1);
      chk($sformatf("seq_done%0d", i), int'(done), 0);
    end
    @(negedge clock);
    chk("seq_done_pulse", int'(done), 1);
    chk("seq_done_busy", int'(busy), 0);
    chk("seq_done_plot", int'(plot), 0);
    chk("seq_hold_x", int'(x), 12);
    chk("seq_hold_y", int'(y), 21);
    @(negedge clock);
    chk("seq_done_single", int'(done), 0);

    // Vector table
    for (int k = 0; k < 10; k++) begin
      run_cmd(tbl[k], cyc, plots, done_at, col_err, dups, oob, fx, fy, lx, ly);
      chk($sformatf("v%0d_draw_cycles", k), cyc, tbl[k].cyc);
      chk($sformatf("v%0d_plots", k), plots, tbl[k].plots);
      chk($sformatf("v%0d_done_at", k), done_at, tbl[k].cyc + 1);
      chk($sformatf("v%0d_colour_err", k), col_err, 0);
      chk($sformatf("v%0d_dups", k), dups, 0);
      chk($sformatf("v%0d_oob", k), oob, 0);
      if (tbl[k].plots > 0) begin
        chk($sformatf("v%0d_first_x", k), fx, tbl[k].fx);
        chk($sformatf("v%0d_first_y", k), fy, tbl[k].fy);
        chk($sformatf("v%0d_last_x", k), lx, tbl[k].lx);
        chk($sformatf("v%0d_last_y", k), ly, tbl[k].ly);
      end
      if (k == 1) begin
        chk("outline_interior_1_1", int'(seen[1][1]), 0);
        chk("outline_interior_2_1", int'(seen[2][1]), 0);
        chk("outline_edge_3_1", int'(seen[3][1]), 1);
      end
      @(negedge clock);
      chk($sformatf("v%0d_done_fell", k), int'(done), 0);
      chk($sformatf("v%0d_idle_busy", k), int'(busy), 0);
    end

    // Empty command; a start held through the done cycle is accepted only afterwards
    issue(2'd0, 3, 3, 0, 5, 1);
    @(negedge clock);
    chk("empty_done_n1", int'(done), 1);
    chk("empty_busy_n1", int'(busy), 0);
    chk("empty_plot_n1", int'(plot), 0);
    issue(2'd0, 30, 40, 2, 1, 6);
    @(negedge clock);
    chk("start_in_done_busy", int'(busy), 0);
    chk("start_in_done_plot", int'(plot), 0);
    chk("start_in_done_done", int'(done), 0);
    @(negedge clock);
    start = 1'b0;
    chk("after_done_accept_busy", int'(busy), 1);
    chk("after_done_accept_x", int'(x), 30);
    t = 0;
    while (!done && t < 20) begin @(negedge clock); t++; end
    chk("after_done_cmd_finished", int'(done), 1);
    @(negedge clock);

    // Reset during the third pixel of a fill
    issue(2'd0, 10, 20, 3, 2, 5);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clock);
      start = 1'b0;
    end
    chk("pre_reset_x", int'(x), 12);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("midreset_plot", int'(plot), 0);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_done", int'(done), 0);
    chk("midreset_x", int'(x), 0);
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (busy || plot) busy_cnt++;
      if (done) done_cnt++;
    end
    chk("midreset_no_activity", busy_cnt, 0);
    chk("midreset_no_done", done_cnt, 0);

`ifdef VGA_RECT_READY_EN
    // Stall pixel 2 for two cycles
    issue(2'd0, 10, 20, 3, 2, 5);
    busy_cnt = 0; done_cnt = -1; t = 0;
    while (t < 15) begin
      @(negedge clock);
      t++;
      start = 1'b0;
      xl[t] = int'(x); pl[t] = int'(plot);
      if (busy) busy_cnt++;
      if (done) begin done_cnt = t; break; end
      pixel_ready = (t == 2 || t == 3) ? 1'b0 : 1'b1;
    end
    pixel_ready = 1'b1;
    chk("stall_draw_cycles", busy_cnt, 8);
    chk("stall_done_at", done_cnt, 9);
    chk("stall_x2", xl[2], 11);
    chk("stall_x3", xl[3], 11);
    chk("stall_x4", xl[4], 11);
    chk("stall_plot3", pl[3], 1);
    chk("stall_plot4", pl[4], 1);
    chk("stall_x5", xl[5], 12);
    @(negedge clock);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_rect_plotter.md
Name: vga_rect_plotter

Overview:
Parametrised pixel-stream draw engine that feeds the vga_adapter plot interface (x, y, colour, plot). It accepts one rectangle command per start/busy/done handshake and emits one pixel per clock in raster order. Supported modes are filled rectangle, outline rectangle and full-screen clear, with clipping at the screen edge. It replaces hand-wired x/y/writeEn logic in the top level for any resolution or colour depth.

Parameters:
SCREEN_W, 160, visible width in pixels
SCREEN_H, 120, visible height in pixels
X_WIDTH, 8, bits of x coordinate, rectangle width and x counter
Y_WIDTH, 7, bits of y coordinate, rectangle height and y counter
COLOUR_BITS, 3, colour word width (3 = 1 bit per channel)

Ports:
clock  in  1  system clock (CLOCK_50 domain)
reset  in  1  synchronous, active-high reset
start  in  1  command strobe; sampled only in IDLE
mode  in  2  0 = fill, 1 = outline, 2 = clear screen, 3 = reserved (treated as fill)
req_x  in  X_WIDTH  rectangle left column
req_y  in  Y_WIDTH  rectangle top row
req_w  in  X_WIDTH  rectangle width; 0 means empty
req_h  in  Y_WIDTH  rectangle height; 0 means empty
req_colour  in  COLOUR_BITS  draw colour
x  out  X_WIDTH  pixel column to vga_adapter
y  out  Y_WIDTH  pixel row to vga_adapter
colour  out  COLOUR_BITS  pixel colour to vga_adapter
plot  out  1  write enable to vga_adapter
busy  out  1  high while a command is in progress
done  out  1  single-cycle completion pulse

Behaviour:
- Reset: state goes to IDLE; x = 0, y = 0, colour = 0, plot = 0, busy = 0, done = 0. Reset mid-draw aborts the draw immediately, with no further plot and no done pulse.
- States: IDLE -> DRAW -> DONE -> IDLE.
- IDLE: when start = 1, latch mode, req_*, and the colour. Clear mode substitutes x0 = 0, y0 = 0, w = SCREEN_W, h = SCREEN_H. If the latched w = 0 or h = 0, go to DONE directly with no pixels. Otherwise go to DRAW with cx = 0, cy = 0.
- Latency: start accepted in cycle N; the first pixel is presented in cycle N+1. busy is high from N+1 until the last DRAW cycle inclusive.
- DRAW: each cycle presents x = x0 + cx and y = y0 + cy, then advances cx. When cx = w-1, cx wraps to 0 and cy increments. The last pixel is at cx = w-1, cy = h-1, and the next state is DONE. A DRAW always lasts exactly w*h cycles.
- Address sums are computed at X_WIDTH+1 and Y_WIDTH+1 bits. If the sum is >= SCREEN_W or >= SCREEN_H, plot = 0 for that cycle (clipped). There is no wrap-around onto the opposite edge.
- Outline mode: plot = 1 only when cx = 0, cx = w-1, cy = 0 or cy = h-1 (and the pixel is not clipped). Interior cycles still elapse with plot = 0.
- Fill and clear modes: plot = 1 on every unclipped DRAW cycle.
- Outputs x, y and colour are registered. plot is registered and aligned with x and y. In IDLE and DONE, plot = 0 and x, y hold their last values.
- DONE: done = 1 for exactly one cycle, busy = 0, then return to IDLE. start in DONE is ignored; the earliest new accept is the cycle after done.
- start or req_* changes while busy are ignored, because the command was latched.

Optional Feature:
Macro VGA_RECT_READY_EN.
- When defined: adds input port pixel_ready (1 bit). In DRAW, if pixel_ready = 0, the x, y, colour and plot outputs and the counters hold their values, and plot remains asserted for the held pixel. The pixel advances only on a cycle where pixel_ready = 1. The DRAW duration becomes w*h cycles plus the number of stall cycles. Reset overrides a stall.
- When undefined: there is no pixel_ready port, and the engine advances every cycle.

Test Plan:
1. Reset, then fill x=10 y=20 w=3 h=2 colour=5 -> plot on 6 consecutive cycles starting N+1, at (10,20),(11,20),(12,20),(10,21),(11,21),(12,21), colour 5; done pulse at N+7; busy high for 6 cycles.
2. Outline x=0 y=0 w=4 h=3 -> 12 DRAW cycles, plot=1 on 10 border pixels, plot=0 at (1,1) and (2,1).
3. Clip: fill x=158 y=119 w=4 h=2 -> 8 DRAW cycles; plot=1 only at (158,119) and (159,119).
4. Clear colour=0 -> 19200 DRAW cycles, every pixel of 160x120 plotted once, then a single done pulse; start pulses during busy are ignored.
5. Empty command w=0 h=5 -> no plot; done at N+1; a second start asserted during done is not accepted.
6. Reset asserted mid-fill (cycle 3 of 6) -> plot=0 and busy=0 on the next cycle, no done pulse; with VGA_RECT_READY_EN, pixel_ready low for 2 cycles on pixel 2 -> pixel 2 held, total 8 DRAW cycles for a 3x2 fill.
